// File: rtl/temporal_window_gen.sv
// rtl/temporal_window_gen.sv - packs co-located pixels of the last NUM_FRAMES frames into one window
// One-cycle read/modify/write pipeline over a per-pixel history memory.
module temporal_window_gen #(
  parameter int VALUE_BITS   = 8,
  parameter int NUM_FRAMES   = 3,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             sof,
  input  logic [VALUE_BITS-1:0]            value_in,
  output logic [VALUE_BITS*NUM_FRAMES-1:0] values_out,
  output logic                             valid_out,
  output logic                             frame_err
);

  localparam int HW = VALUE_BITS * (NUM_FRAMES - 1);
  localparam int AW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int FW = $clog2(NUM_FRAMES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIXELS - 1);
  localparam logic [FW-1:0] FULL_FF   = FW'(NUM_FRAMES - 1);

  logic [HW-1:0]         r_mem [FRAME_PIXELS];
  logic [AW-1:0]         r_addr;
  logic [FW-1:0]         r_ff;
  logic [VALUE_BITS-1:0] r_pix;
  logic [AW-1:0]         r_wr_addr;
  logic [HW-1:0]         r_hist;
  logic                  r_we;
  logic                  r_valid;
  logic                  r_err;

  logic                  w_err;
  logic [AW-1:0]         w_rd_addr;
  logic [AW-1:0]         w_next_addr;
  logic [FW-1:0]         w_ff_eff;
  logic [FW-1:0]         w_next_ff;
  logic                  w_wrap;
  logic [HW-1:0]         w_mem_rd;
  logic [HW-1:0]         w_rd_raw;
  logic [HW-1:0]         w_rd_masked;
  logic [HW-1:0]         w_wr_data;

  // A premature sof restarts the history, so the window it produces already sees zero filled frames.
  assign w_err       = en && sof && (r_addr != '0);
  assign w_rd_addr   = sof ? '0 : r_addr;
  assign w_wrap      = (w_rd_addr == LAST_ADDR);
  assign w_next_addr = w_wrap ? '0 : w_rd_addr + AW'(1);
  assign w_ff_eff    = w_err ? '0 : r_ff;
  assign w_next_ff   = (w_wrap && (w_ff_eff != FULL_FF)) ? w_ff_eff + FW'(1) : w_ff_eff;

  generate
    if (NUM_FRAMES == 2) begin : g_wr_two
      assign w_wr_data = r_pix;
    end else begin : g_wr_many
      assign w_wr_data = {r_hist[HW-VALUE_BITS-1:0], r_pix};
    end
  endgenerate

  generate
    if (FRAME_PIXELS == 1) begin : g_mem_one
      assign w_mem_rd = r_mem[0];
      always_ff @(posedge clk) begin
        if (r_we && !rst) begin
          r_mem[0] <= w_wr_data;
        end
      end
    end else begin : g_mem_many
      assign w_mem_rd = r_mem[w_rd_addr];
      always_ff @(posedge clk) begin
        if (r_we && !rst) begin
          r_mem[r_wr_addr] <= w_wr_data;
        end
      end
    end
  endgenerate

  // The write of the previous pixel lands at this same edge, so a matching read takes it directly.
  assign w_rd_raw = (r_we && (r_wr_addr == w_rd_addr)) ? w_wr_data : w_mem_rd;

  always_comb begin
    w_rd_masked = '0;
    for (int j = 0; j < NUM_FRAMES - 1; j++) begin
      if (j < int'(w_ff_eff)) begin
        w_rd_masked[VALUE_BITS*j +: VALUE_BITS] = w_rd_raw[VALUE_BITS*j +: VALUE_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_ff      <= '0;
      r_pix     <= '0;
      r_wr_addr <= '0;
      r_hist    <= '0;
      r_we      <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we    <= en;
      r_valid <= en && (w_ff_eff == FULL_FF);
      r_err   <= w_err;
      if (en) begin
        r_addr    <= w_next_addr;
        r_ff      <= w_next_ff;
        r_pix     <= value_in;
        r_wr_addr <= w_rd_addr;
        r_hist    <= w_rd_masked;
      end
    end
  end

  assign values_out = {r_hist, r_pix};
  assign valid_out  = r_valid;
  assign frame_err  = r_err;

endmodule
